etapa_fetch_pc: RTL and testbench
=================================

Name: etapa_fetch_pc

Overview:
Instruction-fetch stage holding the program counter and the IF/ID pipeline register. It sits directly downstream of the branch/jump target selector and consumes its 11-bit pc_salto together with a taken flag from decode. It drives the instruction-memory address, captures the returned instruction into IF/ID, flushes wrong-path fetches on taken branches and jumps, honours hazard-unit stalls, and stops fetching on a HALT instruction.

Parameters:
PC_WIDTH, 11, width of the PC and of every word address (word-addressed instruction memory)
INSTR_WIDTH, 32, instruction width
HALT_OPCODE, 32'hFFFFFFFF, instruction encoding that halts fetch
NOP_INSTR, 32'h00000000, encoding inserted on flush, halt and reset

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  synchronous active-low reset
pc_salto  input  PC_WIDTH  branch/jump destination selected upstream
tomar_salto  input  1  1 = branch/jump taken this cycle; load pc_salto
stall  input  1  hazard-unit stall; hold PC and IF/ID
instr_in  input  INSTR_WIDTH  instruction memory data for instr_addr, valid in the same cycle (combinational ROM read)
instr_addr  output  PC_WIDTH  current PC, driven combinationally from the PC register
if_id_instr  output  INSTR_WIDTH  registered instruction to decode
if_id_pc_mas_uno  output  PC_WIDTH  registered PC+1 of that instruction
if_id_valid  output  1  1 = if_id_instr is a real fetched instruction
halted  output  1  1 = fetch stopped in state HALTED

Behaviour:
- Reset is synchronous: when rst_n=0 at a rising edge: PC=0, if_id_instr=NOP_INSTR, if_id_pc_mas_uno=0, if_id_valid=0, halted=0, state=RUN. Reset overrides every other input in every state, including HALTED.
- The FSM has two states, RUN and HALTED. HALTED is left only through reset.
- RUN, per-edge priority (highest first):
  1. stall=1: PC and all IF/ID registers hold. tomar_salto is ignored, and the hazard unit re-presents it after the stall.
  2. tomar_salto=1: PC<=pc_salto; if_id_instr<=NOP_INSTR, if_id_valid<=0, if_id_pc_mas_uno<=0. This flushes the wrong-path fetch. A HALT_OPCODE on instr_in in this cycle is discarded and causes no transition.
  3. instr_in==HALT_OPCODE: the HALT is latched into IF/ID (valid=1, pc_mas_uno=PC+1); PC holds; state becomes HALTED; halted<=1.
  4. Otherwise: PC<=PC+1; if_id_instr<=instr_in; if_id_pc_mas_uno<=PC+1; if_id_valid<=1.
- HALTED: PC holds. From the first edge after entry: if_id_instr=NOP_INSTR, if_id_valid=0. halted stays 1. stall, tomar_salto and instr_in are ignored.
- Fetch-to-IF/ID latency is one cycle. After a taken branch there is exactly one bubble cycle, then the target instruction appears.
- PC arithmetic is modulo 2^PC_WIDTH: PC 11'h7FF increments to 11'h000 and if_id_pc_mas_uno=11'h000 with no flag. pc_salto is loaded unmodified.
- instr_addr always equals the PC register, including during stall and HALTED.

Optional Feature:
Macro FETCH_STEP_EN.
- Defined: adds input port step (1 bit) after stall. In RUN the effective stall is (stall | ~step), so the stage advances, branches or halts only on edges where step=1. This gives single-instruction stepping for the debug unit. Reset and HALTED behaviour are unchanged.
- Undefined: the port is absent and the stage behaves as if step were tied to 1.

Test Plan:
- Reset then free run with instr_in=32'h20010005 at addresses 0..3 -> instr_addr 0,1,2,3 on successive cycles; if_id_pc_mas_uno 1,2,3 one cycle later; if_id_valid=1 from the first edge after reset release.
- At PC=5, tomar_salto=1, pc_salto=11'h040 -> next cycle instr_addr=11'h040, if_id_valid=0, if_id_instr=0; the cycle after, if_id_pc_mas_uno=11'h041 with valid=1.
- stall=1 for 3 cycles at PC=8 with tomar_salto=1 throughout -> PC stays 8 and IF/ID unchanged; branch not taken during stall. Drop stall with tomar_salto=1, pc_salto=11'h010 -> PC=11'h010 and a flush.
- PC=11'h7FF, no branch -> PC=11'h000, if_id_pc_mas_uno=11'h000.
- instr_in=32'hFFFFFFFF at PC=11'h00C -> IF/ID holds HALT with valid=1 and pc_mas_uno=11'h00D; halted=1; next cycle valid=0; PC stays 11'h00C with stimulus applied. Same HALT together with tomar_salto=1 -> no halt, flush. rst_n=0 while halted -> PC=0, halted=0.
- FETCH_STEP_EN: step pulsed for 1 cycle every 4 cycles from PC=0 -> PC advances exactly one per pulse (0,1,2), with IF/ID held between pulses.

Source files
------------

// File: rtl/etapa_fetch_pc.sv
// Instruction-fetch stage: program counter, IF/ID pipeline register, branch flush,
// hazard stall and HALT detection. Define FETCH_STEP_EN to add the debug single-step input.
module etapa_fetch_pc #(
  parameter int                     PC_WIDTH    = 11,
  parameter int                     INSTR_WIDTH = 32,
  parameter logic [INSTR_WIDTH-1:0] HALT_OPCODE = 32'hFFFFFFFF,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = 32'h00000000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [PC_WIDTH-1:0]    pc_salto,
  input  logic                   tomar_salto,
  input  logic                   stall,
`ifdef FETCH_STEP_EN
  input  logic                   step,
`endif
  input  logic [INSTR_WIDTH-1:0] instr_in,
  output logic [PC_WIDTH-1:0]    instr_addr,
  output logic [INSTR_WIDTH-1:0] if_id_instr,
  output logic [PC_WIDTH-1:0]    if_id_pc_mas_uno,
  output logic                   if_id_valid,
  output logic                   halted
);

  typedef enum logic {S_RUN, S_HALTED} state_t;

  state_t                 state, next_state;
  logic [PC_WIDTH-1:0]    pc, pc_next, pc_inc;
  logic [INSTR_WIDTH-1:0] instr_next;
  logic [PC_WIDTH-1:0]    mas_uno_next;
  logic                   valid_next;
  logic                   stall_eff;
  logic                   is_halt;

`ifdef FETCH_STEP_EN
  assign stall_eff = stall | ~step;
`else
  assign stall_eff = stall;
`endif

  assign pc_inc     = pc + PC_WIDTH'(1);
  assign is_halt    = (instr_in == HALT_OPCODE);
  assign instr_addr = pc;
  assign halted     = (state == S_HALTED);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_RUN;
    else        state <= next_state;
  end

  // A HALT only counts when the stage actually advances and no branch flushes it.
  always_comb begin
    next_state = state;
    if (state == S_RUN && !stall_eff && !tomar_salto && is_halt)
      next_state = S_HALTED;
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    pc_next      = pc;
    instr_next   = if_id_instr;
    mas_uno_next = if_id_pc_mas_uno;
    valid_next   = if_id_valid;
    unique case (state)
      S_RUN: begin
        if (stall_eff) begin
          // hold everything; the hazard unit re-presents any branch later
        end else if (tomar_salto) begin
          pc_next      = pc_salto;
          instr_next   = NOP_INSTR;
          mas_uno_next = '0;
          valid_next   = 1'b0;
        end else if (is_halt) begin
          instr_next   = instr_in;
          mas_uno_next = pc_inc;
          valid_next   = 1'b1;
        end else begin
          pc_next      = pc_inc;
          instr_next   = instr_in;
          mas_uno_next = pc_inc;
          valid_next   = 1'b1;
        end
      end
      S_HALTED: begin
        instr_next = NOP_INSTR;
        valid_next = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc               <= '0;
      if_id_instr      <= NOP_INSTR;
      if_id_pc_mas_uno <= '0;
      if_id_valid      <= 1'b0;
    end else begin
      pc               <= pc_next;
      if_id_instr      <= instr_next;
      if_id_pc_mas_uno <= mas_uno_next;
      if_id_valid      <= valid_next;
    end
  end

endmodule

// File: tb/tb_etapa_fetch_pc.sv
// Bench for etapa_fetch_pc: behavioural model checked every cycle plus directed literal checks.
module tb_etapa_fetch_pc;

  localparam logic [31:0] HALT = 32'hFFFFFFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] pc_salto;
  logic        tomar_salto;
  logic        stall;
  logic        step;
  logic [31:0] instr_in;
  logic [10:0] instr_addr;
  logic [31:0] if_id_instr;
  logic [10:0] if_id_pc_mas_uno;
  logic        if_id_valid;
  logic        halted;
  logic        halt_en;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  etapa_fetch_pc dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pc_salto         (pc_salto),
    .tomar_salto      (tomar_salto),
    .stall            (stall),
`ifdef FETCH_STEP_EN
    .step             (step),
`endif
    .instr_in         (instr_in),
    .instr_addr       (instr_addr),
    .if_id_instr      (if_id_instr),
    .if_id_pc_mas_uno (if_id_pc_mas_uno),
    .if_id_valid      (if_id_valid),
    .halted           (halted)
  );

  // Combinational ROM: each word tags its own address; optional HALT at 0x00C.
  function automatic logic [31:0] rom(input logic [10:0] a);
    if (halt_en && a == 11'h00C) return HALT;
    return 32'h2001_0000 | {21'd0, a};
  endfunction

  always_comb instr_in = rom(instr_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic over the stage's visible state.
  int          m_pc, m_mas;
  logic [31:0] m_instr;
  bit          m_valid, m_halted, m_live = 0;
  bit          eff_stall;

  always @(posedge clk) begin
`ifdef FETCH_STEP_EN
    eff_stall = stall || !step;
`else
    eff_stall = stall;
`endif
    if (!rst_n) begin
      m_pc = 0; m_mas = 0; m_instr = 0; m_valid = 0; m_halted = 0; m_live = 1;
    end else if (m_halted) begin
      m_instr = 0; m_valid = 0;
    end else if (eff_stall) begin
    end else if (tomar_salto) begin
      m_pc = int'(pc_salto); m_instr = 0; m_mas = 0; m_valid = 0;
    end else if (instr_in == HALT) begin
      m_instr = instr_in; m_mas = (m_pc + 1) % 2048; m_valid = 1; m_halted = 1;
    end else begin
      m_instr = instr_in; m_mas = (m_pc + 1) % 2048; m_valid = 1; m_pc = (m_pc + 1) % 2048;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("model_addr",    {21'd0, instr_addr},       m_pc);
      check("model_instr",   if_id_instr,               m_instr);
      check("model_mas_uno", {21'd0, if_id_pc_mas_uno}, m_mas);
      check("model_valid",   {31'd0, if_id_valid},      {31'd0, m_valid});
      check("model_halted",  {31'd0, halted},           {31'd0, m_halted});
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic branch(input logic [10:0] dst);
    tomar_salto = 1'b1; pc_salto = dst;
    tick();
    tomar_salto = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; tomar_salto = 1'b0; stall = 1'b0; step = 1'b1;
    pc_salto = '0; halt_en = 1'b0;
    tick(); tick();
    check("rst_addr",   {21'd0, instr_addr}, 32'd0);
    check("rst_valid",  {31'd0, if_id_valid}, 32'd0);
    check("rst_instr",  if_id_instr, 32'h0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    rst_n = 1'b1;

    // Free run: one instruction per cycle, IF/ID one cycle behind.
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("run_addr",  {21'd0, instr_addr}, i);
      check("run_mas",   {21'd0, if_id_pc_mas_uno}, i);
      check("run_instr", if_id_instr, 32'h2001_0000 + i - 1);
      check("run_valid", {31'd0, if_id_valid}, 32'd1);
    end

    // Taken branch at PC=5: one bubble, then the target.
    branch(11'h040);
    check("br_addr",  {21'd0, instr_addr}, 32'h040);
    check("br_valid", {31'd0, if_id_valid}, 32'd0);
    check("br_instr", if_id_instr, 32'h0);
    tick();
    check("br_tgt_mas",   {21'd0, if_id_pc_mas_uno}, 32'h041);
    check("br_tgt_instr", if_id_instr, 32'h2001_0040);
    check("br_tgt_valid", {31'd0, if_id_valid}, 32'd1);

    // Stall at PC=8 with a pending branch that must be ignored.
    branch(11'h007);
    tick();
    stall = 1'b1; tomar_salto = 1'b1; pc_salto = 11'h010;
    repeat (3) tick();
    check("stall_addr",  {21'd0, instr_addr}, 32'h008);
    check("stall_mas",   {21'd0, if_id_pc_mas_uno}, 32'h008);
    check("stall_instr", if_id_instr, 32'h2001_0007);
    stall = 1'b0;
    tick();
    tomar_salto = 1'b0;
    check("unstall_addr",  {21'd0, instr_addr}, 32'h010);
    check("unstall_valid", {31'd0, if_id_valid}, 32'd0);

    // PC wrap-around.
    branch(11'h7FF);
    tick();
    check("wrap_addr",  {21'd0, instr_addr}, 32'h000);
    check("wrap_mas",   {21'd0, if_id_pc_mas_uno}, 32'h000);
    check("wrap_instr", if_id_instr, 32'h2001_07FF);

    // HALT fetched together with a taken branch is discarded.
    halt_en = 1'b1;
    branch(11'h00C);
    branch(11'h020);
    check("haltbr_addr",   {21'd0, instr_addr}, 32'h020);
    check("haltbr_halted", {31'd0, halted}, 32'd0);
    check("haltbr_valid",  {31'd0, if_id_valid}, 32'd0);

    // Real HALT at 0x00C.
    branch(11'h00C);
    tick();
    check("halt_instr",  if_id_instr, HALT);
    check("halt_valid",  {31'd0, if_id_valid}, 32'd1);
    check("halt_mas",    {21'd0, if_id_pc_mas_uno}, 32'h00D);
    check("halt_flag",   {31'd0, halted}, 32'd1);
    check("halt_addr",   {21'd0, instr_addr}, 32'h00C);
    tomar_salto = 1'b1; pc_salto = 11'h055;
    for (int i = 0; i < 3; i++) begin
      stall = i[0];
      tick();
      check("halted_addr",  {21'd0, instr_addr}, 32'h00C);
      check("halted_valid", {31'd0, if_id_valid}, 32'd0);
      check("halted_instr", if_id_instr, 32'h0);
      check("halted_flag",  {31'd0, halted}, 32'd1);
    end
    tomar_salto = 1'b0; stall = 1'b0;

    // Reset leaves HALTED.
    rst_n = 1'b0;
    tick();
    check("unhalt_addr", {21'd0, instr_addr}, 32'd0);
    check("unhalt_flag", {31'd0, halted}, 32'd0);
    halt_en = 1'b0;
    rst_n = 1'b1;
    tick(); tick();
    check("post_addr", {21'd0, instr_addr}, 32'd2);

`ifdef FETCH_STEP_EN
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int p = 1; p <= 3; p++) begin
      step = 1'b0;
      repeat (3) tick();
      check("step_hold_addr", {21'd0, instr_addr}, p - 1);
      step = 1'b1;
      tick();
      check("step_addr", {21'd0, instr_addr}, p);
      check("step_mas",  {21'd0, if_id_pc_mas_uno}, p);
    end
    step = 1'b1;
`endif

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
